// File: rtl/mul_issue_ctrl.sv
// mul_issue_ctrl: operand queue plus issue FSM driving a multi-cycle Booth multiplier.
// Define MUL_TIMEOUT_EN to add a per-multiply watchdog that aborts with out_err.
module mul_issue_ctrl #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_x,
  input  logic [15:0] in_y,
  input  logic [3:0]  in_tag,
  output logic        mul_start,
  output logic [15:0] mul_x,
  output logic [15:0] mul_y,
  input  logic        mul_busy,
  input  logic [31:0] mul_z,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_z,
  output logic [3:0]  out_tag,
  output logic        out_err,
  output logic [4:0]  q_count
);
  localparam int PW = $clog2(FIFO_DEPTH);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, HOLD} state_e;
  state_e state_q, state_d;
  logic [15:0] x_mem [FIFO_DEPTH];
  logic [15:0] y_mem [FIFO_DEPTH];
  logic [3:0]  t_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [4:0]  count_q, count_d;
  logic [15:0] mul_x_q, mul_x_d, mul_y_q, mul_y_d;
  logic [3:0]  tag_q, tag_d, out_tag_q, out_tag_d;
  logic [31:0] out_z_q, out_z_d;
  logic push, pop, empty, issue_go, capture, abort;
  assign empty     = count_q == 5'd0;
  assign in_ready  = count_q < 5'(FIFO_DEPTH);
  assign push      = in_valid && in_ready;
  assign pop       = state_q == ISSUE && !empty;
  assign issue_go  = state_q == IDLE && !empty && !mul_busy;
  assign capture   = state_q == WAIT_DONE && !mul_busy;
  assign mul_start = state_q == ISSUE;
  assign out_valid = state_q == HOLD;
  assign mul_x     = mul_x_q;
  assign mul_y     = mul_y_q;
  assign out_z     = out_z_q;
  assign out_tag   = out_tag_q;
  assign q_count   = count_q;
`ifdef MUL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] cnt_q, cnt_d;
  logic err_q, err_d, waiting;
  assign waiting = state_q == WAIT_BUSY || state_q == WAIT_DONE;
  // a product landing on the final watchdog cycle still wins over the abort
  assign abort   = waiting && !capture && cnt_q == TW'(TIMEOUT_CYCLES - 1);
  assign cnt_d   = waiting && !abort ? cnt_q + 1'b1 : '0;
  assign err_d   = abort ? 1'b1 : (state_q == HOLD && out_ready) ? 1'b0 : err_q;
  assign out_err = err_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
`else
  assign abort   = 1'b0;
  assign out_err = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      state_d = issue_go ? ISSUE : IDLE;
      ISSUE:     state_d = WAIT_BUSY;
      WAIT_BUSY: state_d = abort ? HOLD : mul_busy ? WAIT_DONE : WAIT_BUSY;
      WAIT_DONE: state_d = (capture || abort) ? HOLD : WAIT_DONE;
      HOLD:      state_d = out_ready ? IDLE : HOLD;
      default:   state_d = IDLE;
    endcase
  end
  always_comb begin
    wr_ptr_d  = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d  = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d   = count_q + 5'(push) - 5'(pop);
    mul_x_d   = issue_go ? x_mem[rd_ptr_q] : mul_x_q;
    mul_y_d   = issue_go ? y_mem[rd_ptr_q] : mul_y_q;
    tag_d     = issue_go ? t_mem[rd_ptr_q] : tag_q;
    out_z_d   = capture ? mul_z : abort ? 32'd0 : out_z_q;
    out_tag_d = (capture || abort) ? tag_q : out_tag_q;
  end
  // queue storage needs no reset; only pointers and count define its contents
  always_ff @(posedge clk)
    if (push) begin
      x_mem[wr_ptr_q] <= in_x;
      y_mem[wr_ptr_q] <= in_y;
      t_mem[wr_ptr_q] <= in_tag;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      mul_x_q   <= '0;
      mul_y_q   <= '0;
      tag_q     <= '0;
      out_z_q   <= '0;
      out_tag_q <= '0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      mul_x_q   <= mul_x_d;
      mul_y_q   <= mul_y_d;
      tag_q     <= tag_d;
      out_z_q   <= out_z_d;
      out_tag_q <= out_tag_d;
    end
endmodule

// File: tb/tb_mul_issue_ctrl.sv
// tb_mul_issue_ctrl: randomized bench for mul_issue_ctrl with a 17-cycle Booth multiplier model.
module tb_mul_issue_ctrl;
  logic clk = 1'b0, rst_n = 1'b0;
  logic in_valid = 1'b0, in_ready, mul_start, mul_busy, out_valid, out_ready = 1'b0, out_err;
  logic [15:0] in_x = '0, in_y = '0, mul_x, mul_y;
  logic [3:0] in_tag = '0, out_tag;
  logic [31:0] mul_z, out_z;
  logic [4:0] q_count;
  int n_tests = 0, n_fail = 0, cyc = 0;
  logic [31:0] exp_z[$];
  logic [3:0] exp_t[$];
  logic mul_disc = 1'b0, busy_m;
  logic [4:0] cnt_m;
  logic [15:0] px, py;
  logic [31:0] z_m;

  mul_issue_ctrl dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .in_tag(in_tag), .mul_start(mul_start),
    .mul_x(mul_x), .mul_y(mul_y), .mul_busy(mul_busy), .mul_z(mul_z),
    .out_valid(out_valid), .out_ready(out_ready), .out_z(out_z),
    .out_tag(out_tag), .out_err(out_err), .q_count(q_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
    logic signed [31:0] sa, sb;
    sa = {{16{a[15]}}, a};
    sb = {{16{b[15]}}, b};
    return sa * sb;
  endfunction

  function automatic logic [15:0] rnd16();
    case ($urandom_range(0, 5))
      0: return 16'h8000;
      1: return 16'hFFFF;
      2: return 16'h0000;
      default: return 16'($urandom);
    endcase
  endfunction

  // Booth multiplier model: busy for 17 cycles, product garbage until final
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      busy_m <= 1'b0; cnt_m <= '0; z_m <= '0; px <= '0; py <= '0;
    end else if (mul_start) begin
      busy_m <= 1'b1; cnt_m <= 5'd16; z_m <= $urandom; px <= mul_x; py <= mul_y;
    end else if (busy_m) begin
      if (cnt_m == 0) begin
        busy_m <= 1'b0;
        z_m <= ref_mul(px, py);
      end else cnt_m <= cnt_m - 1'b1;
    end
  assign mul_busy = mul_disc ? 1'b0 : busy_m;
  assign mul_z = z_m;

  always @(negedge clk)
    if (rst_n && mul_start && mul_busy) begin
      n_fail++;
      $display("FAIL start_while_busy: mul_start=%b mul_busy=%b, required no start while busy", mul_start, mul_busy);
    end

  task automatic send(input logic [15:0] x, input logic [15:0] y, input logic [3:0] t, output int acc);
    logic ok;
    in_valid = 1'b1; in_x = x; in_y = y; in_tag = t; acc = -1;
    for (int i = 0; i < 200; i++) begin
      ok = in_ready;
      @(negedge clk);
      if (ok) begin acc = cyc; break; end
    end
    in_valid = 1'b0;
    n_tests++;
    if (acc < 0) begin
      n_fail++;
      $display("FAIL send_accept: tag %0d never accepted, required acceptance within 200 cycles", t);
    end else begin
      exp_z.push_back(ref_mul(x, y));
      exp_t.push_back(t);
    end
  endtask

  task automatic get_result(input int max_wait, input int hold, output logic got,
                            output logic [31:0] z, output logic [3:0] t, output logic e, output int seen);
    got = 1'b0; z = '0; t = '0; e = 1'b0; seen = 0;
    for (int i = 0; i < max_wait; i++) begin
      if (out_valid) begin got = 1'b1; break; end
      @(negedge clk);
    end
    if (got) begin
      seen = cyc;
      repeat (hold) @(negedge clk);
      z = out_z; t = out_tag; e = out_err;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
    end
  endtask

  task automatic check_result(input string name, input logic got, input logic [31:0] z,
                              input logic [3:0] t, input logic e);
    logic [31:0] ez;
    logic [3:0] et;
    ez = exp_z.size() > 0 ? exp_z.pop_front() : 32'hDEAD_BEEF;
    et = exp_t.size() > 0 ? exp_t.pop_front() : 4'hF;
    n_tests++;
    if (!got) begin
      n_fail++;
      $display("FAIL %s_timeout: no out_valid, required result z=%h tag=%0d", name, ez, et);
    end else if (z !== ez || t !== et || e !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: got z=%h tag=%0d err=%b, required z=%h tag=%0d err=0", name, z, t, e, ez, et);
    end
  endtask

  task automatic test_reset();
    n_tests++;
    if (q_count !== 0 || out_valid !== 0 || mul_start !== 0 || out_err !== 0 || mul_x !== 0 ||
        mul_y !== 0 || out_z !== 0 || out_tag !== 0 || in_ready !== 1) begin
      n_fail++;
      $display("FAIL reset_state: q=%0d ov=%b st=%b err=%b x=%h y=%h z=%h tag=%0d rdy=%b, required all 0 and rdy=1",
               q_count, out_valid, mul_start, out_err, mul_x, mul_y, out_z, out_tag, in_ready);
    end
  endtask

  task automatic test_basic();
    int acc, seen;
    logic got, e;
    logic [31:0] z;
    logic [3:0] t;
    send(16'd3, 16'd5, 4'd1, acc);
    get_result(60, 0, got, z, t, e, seen);
    n_tests++;
    if (!got || seen - acc != 20) begin
      n_fail++;
      $display("FAIL basic_latency: got=%b latency=%0d, required 20", got, seen - acc);
    end
    n_tests++;
    if (z !== 32'h0000_000F) begin
      n_fail++;
      $display("FAIL basic_value: z=%h, required 0000000f", z);
    end
    check_result("basic", got, z, t, e);
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_clear: out_valid=%b after accept, required 0", out_valid);
    end
  endtask

  task automatic test_signed();
    int acc, seen;
    logic got, e;
    logic [31:0] z;
    logic [3:0] t;
    send(16'hFFFE, 16'd7, 4'd2, acc);
    get_result(60, 1, got, z, t, e, seen);
    n_tests++;
    if (z !== 32'hFFFF_FFF2) begin
      n_fail++;
      $display("FAIL signed_neg: z=%h, required fffffff2", z);
    end
    check_result("signed_neg", got, z, t, e);
    send(16'h8000, 16'h8000, 4'd3, acc);
    get_result(60, 0, got, z, t, e, seen);
    n_tests++;
    if (z !== 32'h4000_0000) begin
      n_fail++;
      $display("FAIL signed_min: z=%h, required 40000000", z);
    end
    check_result("signed_min", got, z, t, e);
  endtask

  task automatic test_back_to_back();
    int acc, prev, seen;
    logic got, e;
    logic [31:0] z;
    logic [3:0] t;
    prev = -1;
    for (int i = 0; i < 5; i++) begin
      send(rnd16(), rnd16(), 4'(i), acc);
      n_tests++;
      if (prev >= 0 && acc - prev != 1) begin
        n_fail++;
        $display("FAIL b2b_accept%0d: gap=%0d cycles, required 1", i, acc - prev);
      end
      prev = acc;
    end
    n_tests++;
    if (q_count !== 5'd4 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_full: q_count=%0d in_ready=%b, required 4 and 0", q_count, in_ready);
    end
    for (int i = 0; i < 5; i++) begin
      get_result(60, 0, got, z, t, e, seen);
      n_tests++;
      if (t !== 4'(i)) begin
        n_fail++;
        $display("FAIL b2b_order%0d: tag=%0d, required %0d", i, t, i);
      end
      check_result("b2b", got, z, t, e);
    end
  endtask

  task automatic test_hold_stall();
    int acc, seen;
    logic got, e, bad;
    logic [31:0] z, z0;
    logic [3:0] t, t0;
    send(rnd16(), rnd16(), 4'd5, acc);
    send(rnd16(), rnd16(), 4'd6, acc);
    got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      if (out_valid) got = 1'b1; else @(negedge clk);
    end
    z0 = out_z; t0 = out_tag; bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!out_valid || out_z !== z0 || out_tag !== t0 || out_err !== 1'b0 || mul_start) bad = 1'b1;
    end
    n_tests++;
    if (!got || bad) begin
      n_fail++;
      $display("FAIL hold_stable: got=%b z=%h/%h tag=%0d/%0d start=%b, required stable hold, no start",
               got, out_z, z0, out_tag, t0, mul_start);
    end
    get_result(5, 0, got, z, t, e, seen);
    check_result("hold_first", got, z, t, e);
    get_result(60, 0, got, z, t, e, seen);
    check_result("hold_second", got, z, t, e);
  endtask

  task automatic test_random();
    int n;
    n = 24;
    fork
      begin
        int acc;
        for (int i = 0; i < n; i++) begin
          send(rnd16(), rnd16(), 4'(i), acc);
          repeat ($urandom_range(0, 2)) @(negedge clk);
        end
      end
      begin
        int seen;
        logic got, e;
        logic [31:0] z;
        logic [3:0] t;
        for (int j = 0; j < n; j++) begin
          get_result(300, $urandom_range(0, 4), got, z, t, e, seen);
          check_result("random", got, z, t, e);
        end
      end
    join
  endtask

  task automatic test_timeout();
    int acc, seen;
    logic got, e;
    logic [31:0] z;
    logic [3:0] t;
    mul_disc = 1'b1;
    send(16'd9, 16'd9, 4'd11, acc);
    void'(exp_z.pop_back());
    void'(exp_t.pop_back());
`ifdef MUL_TIMEOUT_EN
    get_result(80, 0, got, z, t, e, seen);
    n_tests++;
    if (!got || z !== 32'd0 || e !== 1'b1 || t !== 4'd11 || seen - acc != 26) begin
      n_fail++;
      $display("FAIL timeout_abort: got=%b z=%h err=%b tag=%0d latency=%0d, required z=0 err=1 tag=11 latency=26",
               got, z, e, t, seen - acc);
    end
    n_tests++;
    if (out_err !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_clear: out_err=%b after accept, required 0", out_err);
    end
    mul_disc = 1'b0;
`else
    got = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (out_valid || out_err) got = 1'b1;
    end
    n_tests++;
    if (got) begin
      n_fail++;
      $display("FAIL no_watchdog: out_valid/out_err raised with multiplier disconnected, required indefinite wait");
    end
    mul_disc = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
`endif
  endtask

  task automatic test_reset_mid();
    int acc;
    logic bad;
    for (int i = 0; i < 3; i++) send(rnd16(), rnd16(), 4'(7 + i), acc);
    for (int i = 0; i < 40 && !mul_busy; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    n_tests++;
    if (q_count !== 5'd2 || !mul_busy) begin
      n_fail++;
      $display("FAIL rstmid_pre: q_count=%0d busy=%b, required 2 and 1", q_count, mul_busy);
    end
    rst_n = 1'b0;
    @(negedge clk);
    n_tests++;
    if (q_count !== 0 || out_valid !== 0 || mul_start !== 0 || out_err !== 0) begin
      n_fail++;
      $display("FAIL rstmid_during: q=%0d ov=%b st=%b err=%b, required all 0", q_count, out_valid, mul_start, out_err);
    end
    rst_n = 1'b1;
    exp_z.delete();
    exp_t.delete();
    bad = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid || mul_start || q_count != 0) bad = 1'b1;
    end
    n_tests++;
    if (bad) begin
      n_fail++;
      $display("FAIL rstmid_after: ov=%b st=%b q=%0d, required no result, no start, empty", out_valid, mul_start, q_count);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "global timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_basic();
    test_signed();
    test_back_to_back();
    test_hold_stall();
    test_random();
    test_timeout();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
